// File: rtl/branch_pi_pkg.sv
// Shared types and default sizing for the branch_pi request scheduler.
package branch_pi_pkg;

  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_LATENCY = 2;

  // Tag ids are stored at the widest supported size (NUM_REQ up to 16).
  localparam int unsigned MAX_ID_W = 4;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } sched_state_e;

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_enable,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_grant_id
);

  logic [ID_W-1:0] w_idx;
  logic            w_found;

  // Scan ptr, ptr+1, ... (mod NUM_REQ) and take the first asserted request.
  always_comb begin
    o_grant    = '0;
    o_grant_id = '0;
    w_found    = 1'b0;
    w_idx      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = ID_W'((32'(i_ptr) + k) % NUM_REQ);
      if (i_enable && !w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_id     = w_idx;
      end
    end
  end

endmodule

// File: rtl/branch_pi_sched.sv
// Shares one branch_pi datapath between NUM_REQ requesters; ids ride a tag line
// matched to the datapath latency, and a flush FSM drains in-flight work.
module branch_pi_sched
  import branch_pi_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned LATENCY = DEF_LATENCY,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]       o_req_ready,
  input  logic                     i_flush_req,
  output logic                     o_flush_done,
  output logic [WIDTH-1:0]         o_dp_in,
  input  logic [WIDTH-1:0]         i_dp_out_a,
  input  logic [WIDTH-1:0]         i_dp_out_b,
  output logic                     o_rsp_valid,
  output logic [ID_W-1:0]          o_rsp_id,
  output logic [WIDTH-1:0]         o_rsp_data_a,
  output logic [WIDTH-1:0]         o_rsp_data_b,
  output logic                     o_busy
);

  localparam int unsigned CNT_W = $clog2(LATENCY + 1);

  sched_state_e     r_state, w_state_nxt;
  logic [ID_W-1:0]  r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  tag_t             r_tag [LATENCY];
  tag_t             w_tag_in;

  logic               w_arb_en;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_grant_id;
  logic               w_issue;
  logic               w_retire;
  logic               w_unused_id;

  // Reset gates the grant so req_ready/dp_in drop asynchronously with rst_n.
  assign w_arb_en = i_rst_n && (r_state == RUN) && !i_flush_req;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_arb (
    .i_req     (i_req_valid),
    .i_enable  (w_arb_en),
    .i_ptr     (r_ptr),
    .o_grant   (w_grant),
    .o_grant_id(w_grant_id)
  );

  assign w_issue     = |w_grant;
  assign w_retire    = r_tag[LATENCY-1].valid;
  assign o_req_ready = w_grant;

  // Steer the granted lane onto the datapath input; zero when idle.
  always_comb begin
    o_dp_in = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) o_dp_in = i_req_data[i*WIDTH +: WIDTH];
    end
  end

  // Next pointer follows the winner; holds when nothing is granted.
  always_comb begin
    w_ptr_nxt = r_ptr;
    if (w_issue) begin
      w_ptr_nxt = (32'(w_grant_id) == NUM_REQ - 1) ? '0 : w_grant_id + ID_W'(1);
    end
  end

  // Tag entering stage 0 this cycle.
  always_comb begin
    w_tag_in       = '0;
    w_tag_in.valid = w_issue;
    w_tag_in.id    = MAX_ID_W'(w_grant_id);
  end

  // In-flight count: issue and retire in the same cycle cancel out.
  always_comb begin
    w_cnt_nxt = r_cnt;
    unique case ({w_issue, w_retire})
      2'b10:   w_cnt_nxt = r_cnt + CNT_W'(1);
      2'b01:   w_cnt_nxt = r_cnt - CNT_W'(1);
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  // Flush FSM next state; DRAIN exits once the last tag retires.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RUN:   if (i_flush_req) w_state_nxt = DRAIN;
      DRAIN: if (r_cnt == '0 || (r_cnt == CNT_W'(1) && w_retire)) w_state_nxt = DONE;
      DONE:  if (!i_flush_req) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  // Control state: FSM, grant pointer and in-flight count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= RUN;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Tag line shifts every cycle, matching the free-running datapath.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < LATENCY; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= w_tag_in;
      for (int unsigned i = 1; i < LATENCY; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  assign o_rsp_valid  = r_tag[LATENCY-1].valid;
  assign o_rsp_id     = o_rsp_valid ? r_tag[LATENCY-1].id[ID_W-1:0] : '0;
  assign o_rsp_data_a = o_rsp_valid ? i_dp_out_a : '0;
  assign o_rsp_data_b = o_rsp_valid ? i_dp_out_b : '0;
  assign o_busy       = (r_cnt != '0);
  assign o_flush_done = (r_state == DONE);

  // Upper id bits exist only for wide configurations.
  assign w_unused_id = ^r_tag[LATENCY-1].id;

endmodule

// File: doc/branch_pi_sched.md
Name: branch_pi_sched

Overview:
Round-robin scheduler that shares one branch_pi datapath instance between NUM_REQ requesters. Each request word carries a requester ID tag, which travels through a delay line that matches the datapath latency, so every datapath result returns with its owner's ID. A flush FSM drains in-flight work before reconfiguration or reset of downstream logic. The block sits between the requester fabric and the branch_pi instance.

Parameters:
WIDTH, 32, datapath word width (matches branch_pi WIDTH)
NUM_REQ, 4, number of requesters (2..16)
LATENCY, 2, fixed cycles from dp_in sample to valid dp_out_a/b (1..8)
ID_W, $clog2(NUM_REQ), requester ID width (derived)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_data  in  NUM_REQ*WIDTH  request payloads; requester i occupies bits [i*WIDTH +: WIDTH]
req_ready  out  NUM_REQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
flush_req  in  1  level request to stop issuing and drain
flush_done  out  1  high while drained and flush_req is held
dp_in  out  WIDTH  to branch_pi flow_in
dp_out_a  in  WIDTH  from branch_pi flow_out_a
dp_out_b  in  WIDTH  from branch_pi flow_out_b
rsp_valid  out  1  result valid, single-cycle, no backpressure
rsp_id  out  ID_W  owner of the current result
rsp_data_a  out  WIDTH  dp_out_a when rsp_valid, else 0
rsp_data_b  out  WIDTH  dp_out_b when rsp_valid, else 0
busy  out  1  in-flight count nonzero

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: grant pointer 0, all tag stages invalid, in-flight count 0, FSM RUN. Outputs: req_ready 0, rsp_valid 0, rsp_id 0, flush_done 0, busy 0, dp_in 0.
- Arbitration (combinational in RUN only): grant the first i with req_valid[i] high, searching ptr, ptr+1, … mod NUM_REQ. At most one grant per cycle.
- Pointer update: on a grant to i, ptr <= (i+1) mod NUM_REQ. With no grant, ptr holds.
- dp_in = req_data[granted i] when a grant occurs, else 0. The datapath is free-running and is not stalled.
- Tag line: LATENCY stages of {valid, id}. Stage 0 loads {issue, granted id} each cycle, and each stage shifts by one every cycle.
  - rsp_valid = last-stage valid; rsp_id = last-stage id (0 when invalid).
  - Issue at cycle T produces rsp_valid at cycle T+LATENCY.
- In-flight counter, width $clog2(LATENCY+1): +1 on issue, −1 on retire (rsp_valid). Issue and retire in the same cycle leave it unchanged. It never exceeds LATENCY. busy = (count != 0).
- FSM:
  - RUN: grants allowed. flush_req=1 → DRAIN. In that same cycle req_ready is already 0; the check is combinational on flush_req.
  - DRAIN: no grants; the tag line keeps shifting. When count==0 (or count==1 with a retire this cycle) → DONE.
  - DONE: flush_done=1, no grants. flush_req=0 → RUN. flush_req held → stay in DONE.
  - flush_req dropped while in DRAIN: finish the drain, pass through DONE for one cycle, then RUN.
- Boundaries:
  - All requesters valid: strict rotation 0,1,2,3,0,…
  - Single requester valid: granted every cycle, 100% throughput.
  - Requester deasserting req_valid without a grant is legal; there is no lock.
  - rst_n asserted mid-flight: all tags are discarded and no rsp_valid is produced for those issues.

Decomposition:
- Package branch_pi_pkg:
  - localparam defaults for WIDTH, NUM_REQ, LATENCY
  - typedef enum logic [1:0] {RUN, DRAIN, DONE} sched_state_e
  - typedef struct packed tag_t {valid, id}
- Sub-module rr_arbiter (NUM_REQ): inputs req, enable, ptr; outputs grant one-hot and grant_id. Pointer register stays in branch_pi_sched.

Test Plan:
- Reset, then req_valid=4'b1111 for 8 cycles → grants ids 0,1,2,3,0,1,2,3. rsp_id follows the same order starting 2 cycles later (LATENCY=2). rsp_valid stays high continuously.
- Only req_valid[2]=1 with req_data lane 2 = 0x0000_00A5 → req_ready=4'b0100 every cycle, dp_in=0x0000_00A5, rsp_id=2 after 2 cycles. rsp_data_a/b equal the branch_pi reference-model outputs.
- After grant to id 3, ptr=0; present req_valid=4'b1001 → id 0 granted, then id 3.
- Issue 2 words, then raise flush_req in the next cycle → req_ready=0 immediately, busy high. flush_done rises the cycle after the last rsp_valid, stays high while flush_req=1, and grants resume the cycle after flush_req drops.
- flush_req with empty pipe → DRAIN for 1 cycle then DONE. flush_done=1 within 2 cycles.
- Drop rst_n while 2 tags in flight → all outputs 0 asynchronously. After release, no rsp_valid appears and busy=0.
